// File: rtl/piso_reg_pkg.sv
// rtl/piso_reg_pkg.sv - shared types and helpers for the piso_reg serializer
package piso_reg_pkg;

  // Widest word the bit-reverse helper can handle.
  localparam int MAX_W = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Reverse the low 'width' bits of v; bits at and above 'width' come back as 0.
  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v, input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        r[i] = v[width-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - one-entry valid/ready register slice (used when PISO_REG_HOLD_BUF_EN is defined)
module piso_hold_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // The slice only takes a word when empty, so fill and drain never overlap.
  assign s_ready = !valid_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;

  // Occupancy flag: set on fill, cleared when the consumer takes the word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
    end else if (s_valid && s_ready) begin
      valid_q <= 1'b1;
    end else if (valid_q && m_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Payload register; loads only on a fill.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_q <= '0;
    end else if (s_valid && s_ready) begin
      data_q <= s_data;
    end
  end

endmodule

// File: rtl/piso_reg.sv
// rtl/piso_reg.sv - parallel-in serial-out serializer; optional holding buffer via PISO_REG_HOLD_BUF_EN
module piso_reg
  import piso_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_dir,
  input  logic                  tx_en,
  output logic                  serial_out,
  output logic                  shift_en,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  piso_state_t             state;
  piso_state_t             state_nxt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;

  logic                    accept;
  logic                    load_in;
  logic                    load_buf;
  logic                    do_shift;
  logic                    end_word;

  logic                    next_valid;
  logic [DATA_WIDTH-1:0]   next_data;
  logic                    next_dir;

  // The shifter always emits its MSB, so LSB-first words are reversed on load.
  function automatic logic [DATA_WIDTH-1:0] orient(input logic [DATA_WIDTH-1:0] w,
                                                   input logic dir);
    logic [MAX_W-1:0] r;
    r = bit_rev(MAX_W'(w), DATA_WIDTH);
    return dir ? w : r[DATA_WIDTH-1:0];
  endfunction

  assign accept = in_valid && in_ready;
  assign busy   = (state == SHIFT);

`ifdef PISO_REG_HOLD_BUF_EN
  logic [DATA_WIDTH:0] buf_data;
  logic                buf_valid;
  logic                buf_s_ready;

  // While a word is shifting, new words park in the slice; when idle they bypass it
  // so the first bit still appears the cycle after accept.
  piso_hold_buf #(
    .W (DATA_WIDTH + 1)
  ) u_hold_buf (
    .clk     (clk),
    .arst_n  (arst_n),
    .s_data  ({out_dir, in_data}),
    .s_valid (in_valid && (state == SHIFT)),
    .s_ready (buf_s_ready),
    .m_data  (buf_data),
    .m_valid (buf_valid),
    .m_ready (load_buf)
  );

  assign in_ready   = buf_s_ready;
  assign next_valid = buf_valid;
  assign next_data  = buf_data[DATA_WIDTH-1:0];
  assign next_dir   = buf_data[DATA_WIDTH];
`else
  assign in_ready   = (state == IDLE);
  assign next_valid = 1'b0;
  assign next_data  = '0;
  assign next_dir   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath controls and link outputs.
  always_comb begin
    state_nxt  = state;
    load_in    = 1'b0;
    load_buf   = 1'b0;
    do_shift   = 1'b0;
    end_word   = 1'b0;
    shift_en   = 1'b0;
    serial_out = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // A word left in the buffer by an accept on the final bit goes first.
        if (next_valid) begin
          load_buf  = 1'b1;
          state_nxt = SHIFT;
        end else if (accept) begin
          load_in   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en   = tx_en;
        serial_out = shift_reg[DATA_WIDTH-1] & tx_en;
        if (tx_en) begin
          if (bit_cnt == LAST_CNT) begin
            done = 1'b1;
            if (next_valid) begin
              load_buf = 1'b1;
            end else begin
              end_word  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and bit counter; the counter restarts on every load and never wraps.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load_buf) begin
      shift_reg <= orient(next_data, next_dir);
      bit_cnt   <= '0;
    end else if (load_in) begin
      shift_reg <= orient(in_data, out_dir);
      bit_cnt   <= '0;
    end else if (do_shift) begin
      shift_reg <= shift_reg << 1;
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end else if (end_word) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end
  end

endmodule
